// File: rtl/shift_unit_pipeline_if.sv
// Handshake bundle for the shift unit: operation request in, shifted result out.
// master drives requests and consumes results; slave is the execution unit.
interface shift_unit_pipeline_if #(
    parameter int WIDTH     = 32,
    parameter int TAG_WIDTH = 5
);
    localparam int AW = $clog2(WIDTH) + 1;

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_operand;
    logic [AW-1:0]        in_amount;
    logic [1:0]           in_op;
    logic [TAG_WIDTH-1:0] in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_result;
    logic [TAG_WIDTH-1:0] out_tag;
    logic                 out_illegal;

    modport master (
        output in_valid, in_operand, in_amount, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag, out_illegal
    );

    modport slave (
        input  in_valid, in_operand, in_amount, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag, out_illegal
    );
endinterface

// File: rtl/shift_unit_pipeline.sv
// Two-stage SLL/SRL/SRA unit: capture stage, then registered result; result visible one edge after accept.
// Full throughput; a stalled result stage holds its outputs and backs up through in_ready combinationally.
module shift_unit_pipeline #(
    parameter int WIDTH     = 32,
    parameter int TAG_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    shift_unit_pipeline_if.slave  bus
);
    localparam int SW = $clog2(WIDTH);
    localparam int AW = SW + 1;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_ILL = 2'b10,
        OP_SRA = 2'b11
    } op_e;

    // Logical right barrel shifter; the amount MSB means "shifted past the width".
    function automatic logic [WIDTH-1:0] f_shr(input logic [WIDTH-1:0] x, input logic [AW-1:0] n);
        logic [WIDTH-1:0] v;
        v = n[AW-1] ? '0 : x;
        for (int s = 0; s < SW; s++) begin
            if (n[s]) v = v >> (1 << s);
        end
        return v;
    endfunction

    function automatic logic [WIDTH-1:0] f_rev(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < WIDTH; i++) v[i] = x[WIDTH-1-i];
        return v;
    endfunction

    logic                 r_a_vld;
    logic [WIDTH-1:0]     r_a_operand;
    logic [AW-1:0]        r_a_amount;
    op_e                  r_a_op;
    logic [TAG_WIDTH-1:0] r_a_tag;

    logic                 r_b_vld;
    logic [WIDTH-1:0]     r_b_result;
    logic [TAG_WIDTH-1:0] r_b_tag;
    logic                 r_b_illegal;

    logic                 w_b_rdy;
    logic                 w_a_rdy;
    logic                 w_accept;
    logic [WIDTH-1:0]     w_shr;
    logic [WIDTH-1:0]     w_shl;
    logic [WIDTH-1:0]     w_sra;
    logic [WIDTH-1:0]     w_result;
    logic                 w_illegal;

    assign w_b_rdy      = !r_b_vld || bus.out_ready;
    assign w_a_rdy      = !r_a_vld || w_b_rdy;
    assign bus.in_ready = w_a_rdy && !flush && reset;
    assign w_accept     = bus.in_valid && bus.in_ready;

    // Left and arithmetic shifts reuse the single right shifter via bit reversal / inversion.
    assign w_shr = f_shr(r_a_operand, r_a_amount);
    assign w_shl = f_rev(f_shr(f_rev(r_a_operand), r_a_amount));
    assign w_sra = r_a_operand[WIDTH-1] ? ~f_shr(~r_a_operand, r_a_amount) : w_shr;

    always_comb begin
        w_result  = r_a_operand;
        w_illegal = 1'b0;
        case (r_a_op)
            OP_SLL:  w_result = w_shl;
            OP_SRL:  w_result = w_shr;
            OP_SRA:  w_result = w_sra;
            default: w_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_a_vld     <= 1'b0;
            r_a_operand <= '0;
            r_a_amount  <= '0;
            r_a_op      <= OP_SLL;
            r_a_tag     <= '0;
            r_b_vld     <= 1'b0;
            r_b_result  <= '0;
            r_b_tag     <= '0;
            r_b_illegal <= 1'b0;
        end else if (flush) begin
            r_a_vld <= 1'b0;
            r_b_vld <= 1'b0;
        end else begin
            if (w_a_rdy) begin
                r_a_vld <= w_accept;
                if (w_accept) begin
                    r_a_operand <= bus.in_operand;
                    r_a_amount  <= bus.in_amount;
                    r_a_op      <= op_e'(bus.in_op);
                    r_a_tag     <= bus.in_tag;
                end
            end
            if (w_b_rdy) begin
                r_b_vld <= r_a_vld;
                if (r_a_vld) begin
                    r_b_result  <= w_result;
                    r_b_tag     <= r_a_tag;
                    r_b_illegal <= w_illegal;
                end
            end
        end
    end

    assign bus.out_valid   = r_b_vld;
    assign bus.out_result  = r_b_result;
    assign bus.out_tag     = r_b_tag;
    assign bus.out_illegal = r_b_illegal;
endmodule

// File: tb/tb_shift_unit_pipeline.sv
// Bench for shift_unit_pipeline: directed cases with literal results plus a randomized run
// checked every cycle against a queue-based model of the two-deep pipeline.
module tb_shift_unit_pipeline;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;

    shift_unit_pipeline_if #(.WIDTH(32), .TAG_WIDTH(5)) bus();

    shift_unit_pipeline #(.WIDTH(32), .TAG_WIDTH(5)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int edge_cnt = 0;

    always @(posedge clk) edge_cnt++;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        logic        ill;
        int          acc;
    } exp_t;

    exp_t        q[$];
    logic [4:0]  drained[$];
    bit          prev_rst = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] x, input int amt, input logic [1:0] op);
        logic signed [31:0] sx;
        sx = x;
        case (op)
            2'b00:   return (amt >= 32) ? 32'h0 : x << amt;
            2'b01:   return (amt >= 32) ? 32'h0 : x >> amt;
            2'b11:   return sx >>> ((amt >= 32) ? 31 : amt);
            default: return x;
        endcase
    endfunction

    // Monitor: outputs and in_ready are checked against the model, then the model advances
    // by whatever happens at the coming edge.
    always @(negedge clk) begin
        bit vis;
        bit exp_rdy;
        vis = (q.size() > 0) && (q[0].acc < edge_cnt);
        chk("mon_out_valid", bus.out_valid, vis);
        if (vis) begin
            chk("mon_result", bus.out_result, q[0].res);
            chk("mon_tag", bus.out_tag, q[0].tag);
            chk("mon_illegal", bus.out_illegal, q[0].ill);
        end
        if (prev_rst) begin
            chk("mon_rst_result", bus.out_result, 0);
            chk("mon_rst_tag", bus.out_tag, 0);
            chk("mon_rst_illegal", bus.out_illegal, 0);
        end
        exp_rdy = reset && !flush && ((q.size() < 2) || bus.out_ready);
        chk("mon_in_ready", bus.in_ready, exp_rdy);

        if (reset && !flush && bus.out_valid && bus.out_ready)
            drained.push_back(bus.out_tag);

        if (!reset || flush) begin
            q.delete();
        end else begin
            if (vis && bus.out_ready) void'(q.pop_front());
            if (exp_rdy && bus.in_valid)
                q.push_back('{res: ref_shift(bus.in_operand, int'(bus.in_amount), bus.in_op),
                              tag: bus.in_tag, ill: (bus.in_op == 2'b10), acc: edge_cnt + 1});
        end
        prev_rst = !reset;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [31:0] x, input int amt, input logic [1:0] op, input logic [4:0] tag);
        bus.in_valid   = 1'b1;
        bus.in_operand = x;
        bus.in_amount  = 6'(amt);
        bus.in_op      = op;
        bus.in_tag     = tag;
    endtask

    task automatic do_op(input string nm, input logic [31:0] x, input int amt, input logic [1:0] op,
                         input logic [4:0] tag, input logic [31:0] exp, input logic exp_ill);
        bus.out_ready = 1'b1;
        set_op(x, amt, op, tag);
        step();
        bus.in_valid = 1'b0;
        chk({nm, "_lat0_valid"}, bus.out_valid, 0);
        step();
        chk({nm, "_valid"}, bus.out_valid, 1);
        chk({nm, "_result"}, bus.out_result, exp);
        chk({nm, "_tag"}, bus.out_tag, tag);
        chk({nm, "_illegal"}, bus.out_illegal, exp_ill);
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp1;
        bus.in_valid   = 1'b0;
        bus.in_operand = '0;
        bus.in_amount  = '0;
        bus.in_op      = 2'b00;
        bus.in_tag     = '0;
        bus.out_ready  = 1'b1;

        chk("model_sll10", ref_shift(32'hFFFF_FFFF, 10, 2'b00), 32'hFFFF_FC00);
        chk("model_srl10", ref_shift(32'hFFFF_FFFF, 10, 2'b01), 32'h003F_FFFF);
        chk("model_sra32", ref_shift(32'h8000_0000, 32, 2'b11), 32'hFFFF_FFFF);
        chk("model_ill", ref_shift(32'hA5A5_A5A5, 7, 2'b10), 32'hA5A5_A5A5);

        step();
        step();
        chk("reset_in_ready", bus.in_ready, 0);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_out_result", bus.out_result, 0);
        reset = 1'b1;
        step();

        do_op("sll10", 32'hFFFF_FFFF, 10, 2'b00, 5'd1, 32'hFFFF_FC00, 1'b0);
        do_op("srl10", 32'hFFFF_FFFF, 10, 2'b01, 5'd2, 32'h003F_FFFF, 1'b0);
        do_op("sra4", 32'h8000_0000, 4, 2'b11, 5'd3, 32'hF800_0000, 1'b0);
        do_op("sra32_neg", 32'h8000_0000, 32, 2'b11, 5'd4, 32'hFFFF_FFFF, 1'b0);
        do_op("sra32_pos", 32'h7FFF_FFFF, 32, 2'b11, 5'd5, 32'h0000_0000, 1'b0);
        do_op("sll32", 32'h1234_5678, 32, 2'b00, 5'd6, 32'h0000_0000, 1'b0);
        do_op("srl63", 32'hDEAD_BEEF, 63, 2'b01, 5'd7, 32'h0000_0000, 1'b0);
        do_op("amt0", 32'h1234_5678, 0, 2'b11, 5'd8, 32'h1234_5678, 1'b0);
        do_op("illegal", 32'hA5A5_A5A5, 3, 2'b10, 5'd9, 32'hA5A5_A5A5, 1'b1);

        // Back-to-back issue into a stalled output.
        drained.delete();
        exp1 = ref_shift(32'hF0F0_1234, 8, 2'b01);
        bus.out_ready = 1'b0;
        set_op(32'hF0F0_1234, 8, 2'b01, 5'd1);
        step();
        set_op(32'h8000_00FF, 1, 2'b11, 5'd2);
        step();
        set_op(32'h0000_0001, 31, 2'b00, 5'd3);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready_low", bus.in_ready, 0);
            chk("bp_stall_valid", bus.out_valid, 1);
            chk("bp_stall_tag", bus.out_tag, 1);
            chk("bp_stall_result", bus.out_result, exp1);
            if (i < 2) step();
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", bus.in_ready, 1);
        step();
        set_op(32'h0000_FFFF, 16, 2'b00, 5'd4);
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("bp_drain_count", drained.size(), 4);
        for (int i = 0; i < 4 && i < drained.size(); i++)
            chk("bp_order", drained[i], i + 1);

        // Flush with both stages full.
        bus.out_ready = 1'b0;
        set_op(32'h1111_1111, 1, 2'b00, 5'd10);
        step();
        set_op(32'h2222_2222, 2, 2'b01, 5'd11);
        step();
        flush = 1'b1;
        set_op(32'h3333_3333, 3, 2'b00, 5'd12);
        #1;
        chk("flush_in_ready", bus.in_ready, 0);
        step();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("flush_out_valid", bus.out_valid, 0);
        step();
        chk("flush_no_accept", bus.out_valid, 0);
        do_op("post_flush", 32'h0000_00F0, 4, 2'b01, 5'd13, 32'h0000_000F, 1'b0);

        // Reset with both stages full.
        bus.out_ready = 1'b0;
        set_op(32'h4444_4444, 4, 2'b00, 5'd14);
        step();
        set_op(32'h5555_5555, 5, 2'b01, 5'd15);
        step();
        reset = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("rst_low_in_ready", bus.in_ready, 0);
        step();
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_result", bus.out_result, 0);
        chk("rst_out_tag", bus.out_tag, 0);
        chk("rst_out_illegal", bus.out_illegal, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        reset = 1'b1;
        do_op("post_reset", 32'h0000_0003, 2, 2'b00, 5'd16, 32'h0000_000C, 1'b0);

        // Randomized traffic with stalls, flushes and occasional resets.
        for (int c = 0; c < 4000; c++) begin
            int amt;
            amt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) * 16 - (($urandom_range(0, 1) == 1) ? 1 : 0)
                                              : int'($urandom_range(0, 63));
            if (amt < 0) amt = 0;
            bus.in_valid   = ($urandom_range(0, 9) < 7);
            bus.in_operand = $urandom();
            bus.in_amount  = 6'(amt);
            bus.in_op      = 2'($urandom_range(0, 3));
            bus.in_tag     = 5'($urandom_range(0, 31));
            bus.out_ready  = ($urandom_range(0, 9) < 7);
            flush          = ($urandom_range(0, 99) < 3);
            reset          = !($urandom_range(0, 199) < 2);
            step();
        end
        reset = 1'b1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("final_empty", bus.out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/shift_unit_pipeline.md
Name: shift_unit_pipeline

Overview:
- Two-stage pipelined shift execution unit for the phoeniX execute path.
- Accepts RV32I-style shift operations (SLL/SRL/SRA) through a valid/ready handshake and registers the operands.
- Applies the shift combinationally between the stages, reusing the team's barrel shifter for the logical shift. SRA is built on top of it.
- Registers the result for the downstream writeback logic, with full throughput, backpressure and flush.

Parameters:
- WIDTH, 32, data width in bits. Power of two, at least 8.
- TAG_WIDTH, 5, width of the sideband tag (destination register index) carried alongside each operation.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- flush  input  1  synchronous kill of all in-flight operations.
- in_valid  input  1  upstream presents an operation.
- in_ready  output  1  unit can accept this cycle.
- in_operand  input  WIDTH  value to shift.
- in_amount  input  $clog2(WIDTH)+1  shift amount, 0..2*WIDTH-1.
- in_op  input  2  00=SLL, 01=SRL, 11=SRA, 10=illegal.
- in_tag  input  TAG_WIDTH  sideband tag.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts.
- out_result  output  WIDTH  shifted value.
- out_tag  output  TAG_WIDTH  tag of the result.
- out_illegal  output  1  operation used op 10.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-low. The reset port is named as the codebase names it.
- Reset (reset==0 at a rising edge):
  - Clears both stage valid bits and all data registers.
  - out_valid=0, out_result=0, out_tag=0, out_illegal=0.
  - in_ready=0 while reset is low.
  - Reset has priority over flush and over any handshake. Operations in flight mid-reset are discarded, with no output.
- Stage A (capture): registers operand, amount, op and tag when in_valid && in_ready.
- Stage B (result): registers the shift result, tag and illegal flag computed from stage A.
- Ready chain:
  - readyB = !validB || out_ready.
  - readyA = !validA || readyB.
  - in_ready = readyA && !flush && reset.
  - The combinational path out_ready -> in_ready is permitted.
- Latency:
  - An operation accepted at edge N appears on the outputs after edge N+1 (out_valid high in cycle N+1).
  - Throughput is one operation per cycle when out_ready is held high.
- Stall: with out_valid && !out_ready, stage B holds out_result, out_tag and out_illegal stable and unchanged. Stage A holds if it is also full.
- Shift arithmetic:
  - SLL: zero fill from the LSB.
  - SRL: zero fill from the MSB.
  - SRA: sign fill with operand[WIDTH-1], implemented as ~((~x)>>n) when the sign is 1, else x>>n.
  - Amount >= WIDTH: SLL/SRL give all zeros; SRA gives all copies of the sign bit.
  - Amount 0 passes the operand through unchanged.
  - The unit does no masking: the caller masks RV32 amounts to 5 bits before issue.
- Illegal op 10: out_result = operand unchanged, out_illegal=1, and the operation flows through normally.
- Flush (flush==1 at an edge, reset==1):
  - Clears validA and validB and accepts no new input that cycle.
  - A result presented with out_ready in the flush cycle counts as not consumed.
  - The data registers may keep stale values, but out_valid=0.
- Simultaneous accept and drain: when stage B drains and stage A advances in the same cycle, no bubble is inserted and no operation is lost or duplicated.
- Ordering: results leave in strict acceptance order, one handshake per accepted operation.

Test Plan:
- Logical shifts:
  - Operand 0xFFFF_FFFF, amount 10, SLL -> out_result 0xFFFF_FC00 in the cycle after acceptance.
  - Same operand and amount, SRL -> 0x003F_FFFF.
- SRA and boundaries:
  - 0x8000_0000 SRA 4 -> 0xF800_0000.
  - 0x8000_0000 SRA 32 -> 0xFFFF_FFFF.
  - 0x7FFF_FFFF SRA 32 -> 0x0000_0000.
  - 0x1234_5678 SLL 32 -> 0x0000_0000.
  - Amount 0 -> operand unchanged.
- Back-to-back with backpressure:
  - Issue 4 operations on consecutive cycles with tags 1..4, and hold out_ready=0 for 3 cycles.
  - in_ready drops once both stages are full.
  - Outputs stay stable while stalled.
  - After release, tags 1..4 emerge in order with no loss or duplication.
- Illegal op: op 10 on 0xA5A5_A5A5 -> out_illegal=1, out_result 0xA5A5_A5A5.
- Flush:
  - Assert flush with both stages full -> out_valid=0 next cycle.
  - in_ready=0 during the flush cycle; the operation on in_valid that cycle is not accepted.
  - The next operation completes normally.
- Reset mid-operation:
  - Drive reset low for one edge with both stages full -> all outputs 0 and in_ready=0 while low.
  - After reset, the first new operation appears after 2 edges.
